icache_dm: RTL and testbench

Parametrised direct-mapped instruction cache between Fetch and the unified L2. Returns one 32-bit instruction word per cycle on a hit; on a miss it stalls Fetch, refills one 256-bit line from L2 and resumes. Includes whole-cache flush for `fence.i`, and optional hit/miss performance counters.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_dm_if.sv | 27 ++
 rtl/icache_line_store.sv | 48 ++++
 rtl/icache_dm.sv | 116 +++++++++++
 tb/tb_icache_dm.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the direct-mapped instruction cache.
package icache_pkg;

  localparam logic [31:0] NOP            = 32'h00000033;
  localparam int          LINE_BITS      = 256;
  localparam int          WORDS_PER_LINE = LINE_BITS / 32;
  localparam int          OFFSET_BITS    = $clog2(LINE_BITS / 8);

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and L2-side signals of the instruction cache, grouped as one bundle.
interface icache_dm_if;
  import icache_pkg::*;

  logic [31:0]          addr;
  logic                 flush;
  logic                 stall;
  logic [31:0]          out;
  logic [LINE_BITS-1:0] L2_block_read;
  logic                 L2_stall;
  logic                 L2_req;
  logic [31:0]          L2_addr_read;

  // Handshakes: out is valid for addr exactly when stall=0, and Fetch holds addr
  // while stall=1. A refill beat transfers in a cycle with L2_req=1 and
  // L2_stall=0; L2_req stays high and L2_addr_read stays constant until then.
  modport master (
    output addr, flush, L2_block_read, L2_stall,
    input  stall, out, L2_req, L2_addr_read
  );

  modport slave (
    input  addr, flush, L2_block_read, L2_stall,
    output stall, out, L2_req, L2_addr_read
  );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: combinational read, single write port, sync clear-all and
// async reset of the valid bits only (tags and data are never reset).
module icache_line_store import icache_pkg::*; #(
  parameter  int SETS       = 64,
  parameter  int TAG_BITS   = 21,
  parameter  int LINE_W     = LINE_BITS,
  localparam int INDEX_BITS = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_W-1:0]     rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [LINE_W-1:0]     wr_data,
  input  logic                  wr_valid,
  input  logic                  clear_all
);

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_mem  [SETS];
  logic [LINE_W-1:0]   data_mem [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hits, one-line refill from L2 on a miss,
// whole-cache flush. Define ICACHE_PERF_EN to add hit_count/miss_count outputs.
module icache_dm import icache_pkg::*; #(
  parameter int SETS      = 64,
  parameter int LINE_BITS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  icache_dm_if.slave    bus,
  output icache_state_t dbg_state
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS;

  icache_state_t state_q, state_d;
  logic          flush_pend_q;

  logic [INDEX_BITS-1:0]          index;
  logic [TAG_BITS-1:0]            tag;
  logic                           rd_valid;
  logic [TAG_BITS-1:0]            rd_tag;
  logic [LINE_BITS-1:0]           rd_data;
  logic [WORDS_PER_LINE-1:0][31:0] rd_words;
  logic                           hit;
  logic                           we;
  logic                           wr_valid;
  logic                           clear_all;
  logic [1:0]                     unused_byte_sel;

  assign index           = bus.addr[OFFSET_BITS +: INDEX_BITS];
  assign tag             = bus.addr[31 -: TAG_BITS];
  assign unused_byte_sel = bus.addr[1:0];
  assign rd_words        = rd_data;
  assign hit             = rd_valid && (rd_tag == tag);
  assign bus.L2_addr_read = {bus.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign dbg_state       = state_q;

  icache_line_store #(
    .SETS     (SETS),
    .TAG_BITS (TAG_BITS),
    .LINE_W   (LINE_BITS)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .we        (we),
    .wr_index  (index),
    .wr_tag    (tag),
    .wr_data   (bus.L2_block_read),
    .wr_valid  (wr_valid),
    .clear_all (clear_all)
  );

  always_comb begin
    state_d     = state_q;
    bus.stall   = 1'b1;
    bus.out     = NOP;
    bus.L2_req  = 1'b0;
    we          = 1'b0;
    wr_valid    = 1'b0;
    clear_all   = 1'b0;
    case (state_q)
      IDLE: begin
        clear_all = bus.flush;
        if (hit) begin
          bus.stall = 1'b0;
          bus.out   = rd_words[bus.addr[OFFSET_BITS-1:2]];
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        bus.L2_req = 1'b1;
        if (!bus.L2_stall) begin
          // A flush seen at any point of the refill leaves the new line invalid.
          we       = 1'b1;
          wr_valid = !(flush_pend_q || bus.flush);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= (state_q == REFILL) && bus.L2_stall && (flush_pend_q || bus.flush);
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == IDLE) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: vector table of fetches plus hand-written
// flush/reset sequences, with an L2 responder model and an expected-word queue.
module tb_icache_dm;
  import icache_pkg::*;

  logic clk;
  logic rst_n;
  icache_state_t dbg_state;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_dm_if bus ();

  icache_dm #(.SETS(64), .LINE_BITS(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int l2_delay = 0;
  int l2_cnt   = 0;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    int          stalls;
    int          reqs;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] line_a;
    line_a = {a[31:5], 5'b0};
    return 32'h1000 + line_a + {29'd0, a[4:2]};
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] line_a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h1000 + line_a + k;
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // L2 model: answers a refill after l2_delay busy cycles with the modelled line.
  always @(posedge clk) begin
    #2;
    if (bus.L2_req === 1'b1) begin
      if (l2_cnt >= l2_delay) begin
        bus.L2_stall      = 1'b0;
        bus.L2_block_read = make_line(bus.L2_addr_read);
      end else begin
        bus.L2_stall = 1'b1;
      end
      l2_cnt++;
    end else begin
      bus.L2_stall = 1'b1;
      l2_cnt       = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the hit.
  task automatic fetch(input logic [31:0] a, input int d, input int exp_stalls,
                       input int exp_reqs, input int flush_at, input string name);
    int   stalls;
    int   reqs;
    logic prev_req;
    logic done;
    logic [31:0] want;
    stalls   = 0;
    reqs     = 0;
    prev_req = 1'b0;
    done     = 1'b0;
    l2_delay = d;
    bus.addr = a;
    exp_q.push_back(model_word(a));
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      bus.flush = (cyc == flush_at);
      #3;
      if (bus.L2_req && !prev_req) reqs++;
      prev_req = bus.L2_req;
      if (bus.stall) begin
        stalls++;
        if (cyc == 0) begin
          check({name, " miss out"}, bus.out, NOP);
          check({name, " miss req"}, {31'd0, bus.L2_req}, 32'd0);
          check({name, " l2 addr"}, bus.L2_addr_read, {a[31:5], 5'b0});
        end
        if (cyc == 1) check({name, " refill req"}, {31'd0, bus.L2_req}, 32'd1);
      end else begin
        want = exp_q.pop_front();
        check({name, " out"}, bus.out, want);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL %s timeout: no hit within 200 cycles", name);
      void'(exp_q.pop_front());
    end
    check({name, " stalls"}, stalls, exp_stalls);
    check({name, " reqs"}, reqs, exp_reqs);
  endtask

  // Flush pulse while addr hits: this cycle still hits, later lookups miss.
  task automatic do_flush();
    bus.addr  = 32'h0;
    bus.flush = 1'b1;
    #3;
    check("flush same-cycle stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  // ---------------- main test ----------------
  initial begin
    vecs[0]  = '{32'h0000_0000, 3, 5, 1};
    vecs[1]  = '{32'h0000_0004, 0, 0, 0};
    vecs[2]  = '{32'h0000_0008, 0, 0, 0};
    vecs[3]  = '{32'h0000_000C, 0, 0, 0};
    vecs[4]  = '{32'h0000_0010, 0, 0, 0};
    vecs[5]  = '{32'h0000_0014, 0, 0, 0};
    vecs[6]  = '{32'h0000_0018, 0, 0, 0};
    vecs[7]  = '{32'h0000_001C, 0, 0, 0};
    vecs[8]  = '{32'h0000_0800, 1, 3, 1};
    vecs[9]  = '{32'h0000_0000, 0, 2, 1};
    vecs[10] = '{32'h0000_0003, 0, 0, 0};
    vecs[11] = '{32'h0000_001E, 0, 0, 0};
    vecs[12] = '{32'h0000_07E0, 2, 4, 1};
    vecs[13] = '{32'h0000_07FC, 0, 0, 0};

    rst_n             = 1'b0;
    bus.addr          = 32'h0;
    bus.flush         = 1'b0;
    bus.L2_stall      = 1'b1;
    bus.L2_block_read = '0;
    repeat (3) @(posedge clk);
    #4;
    check("reset req", {31'd0, bus.L2_req}, 32'd0);
    check("reset stall", {31'd0, bus.stall}, 32'd1);
    check("reset out", bus.out, NOP);
    check("reset state", {31'd0, dbg_state}, {31'd0, IDLE});
`ifdef ICACHE_PERF_EN
    check("reset hit_count", hit_count, 32'd0);
    check("reset miss_count", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      fetch(vecs[i].addr, vecs[i].delay, vecs[i].stalls, vecs[i].reqs, -1,
            $sformatf("vec%0d", i));

    do_flush();
    fetch(32'h0, 1, 3, 1, -1, "after idle flush");

    do_flush();
    fetch(32'h0, 3, 10, 2, 1, "flush in refill");

    do_flush();
    fetch(32'h0, 0, 4, 2, 1, "flush at fill");

    // Reset in the middle of a long refill.
    do_flush();
    l2_delay = 10;
    bus.addr = 32'h0;
    @(posedge clk);
    #1;
    #3;
    check("pre-reset refill req", {31'd0, bus.L2_req}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset req", {31'd0, bus.L2_req}, 32'd0);
    check("mid reset state", {31'd0, dbg_state}, {31'd0, IDLE});
    check("mid reset stall", {31'd0, bus.stall}, 32'd1);
    check("mid reset out", bus.out, NOP);
`ifdef ICACHE_PERF_EN
    check("mid reset hit_count", hit_count, 32'd0);
    check("mid reset miss_count", miss_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch(32'h0, 0, 2, 1, -1, "after reset");
`ifdef ICACHE_PERF_EN
    check("post reset hit_count", hit_count, 32'd1);
    check("post reset miss_count", miss_count, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
